// File: rtl/batch_sample_scoreboard.sv
// Batch-ordering scoreboard: shadows downsampled input vectors per batch cycle,
// checks pipeline taps against the shadow copy, and monitors the filter output
// for magnitude discontinuities. Sticky flags and saturating counters are readable.
module batch_sample_scoreboard #(
  parameter int N     = 4,
  parameter int DSR   = 1,
  parameter int DEPTH = 32,
  parameter int LANES = 3,
  parameter int RES_W = 24,
  parameter logic [RES_W-1:0] DMAX = 24'h04CCCC,
  parameter int CNT_W = 16,
  localparam int SW = N * DSR,
  localparam int D  = (DEPTH + DSR - 1) / DSR,
  localparam int IW = (D > 1) ? $clog2(D) : 1,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  wr_valid,
  input  logic [1:0]            wr_cycle,
  input  logic [IW-1:0]         wr_idx,
  input  logic [SW-1:0]         wr_data,
  input  logic [LANES-1:0]      chk_valid,
  input  logic [2*LANES-1:0]    chk_cycle,
  input  logic [IW*LANES-1:0]   chk_idx,
  input  logic [SW*LANES-1:0]   chk_data,
  input  logic                  res_valid,
  input  logic [RES_W-1:0]      res_data,
  output logic [LANES-1:0]      err_pulse,
  output logic [LANES-1:0]      err_sticky,
  output logic [LANES-1:0]      uninit_sticky,
  output logic [CNT_W-1:0]      err_count,
  output logic [LW-1:0]         first_lane,
  output logic [IW-1:0]         first_idx,
  output logic [SW-1:0]         first_exp,
  output logic [SW-1:0]         first_act,
  output logic                  disc_pulse,
  output logic [CNT_W-1:0]      disc_count
);

  logic [SW-1:0]   mem [4][D];
  logic [D-1:0]    ent_valid [4];
  logic [1:0]      last_cycle;
  logic            last_seen;

  logic            wr_ok;
  logic            new_epoch;
  logic [D-1:0]    wr_onehot;

  logic [LANES-1:0] mism;
  logic [LANES-1:0] unin;
  logic [1:0]       lane_bank;
  logic [IW-1:0]    lane_idx;
  logic [SW-1:0]    lane_data;
  logic             cap_found;
  logic [LW-1:0]    cap_lane;
  logic [IW-1:0]    cap_idx;
  logic [SW-1:0]    cap_exp;
  logic [SW-1:0]    cap_act;
  logic [LW:0]      pop;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_next;
  logic             first_armed;

  logic [RES_W-1:0] res_abs;
  logic [RES_W-1:0] prev_abs;
  logic             prev_valid;
  logic [RES_W:0]   delta;
  logic             disc_hit;

  function automatic logic [RES_W-1:0] mag(input logic [RES_W-1:0] v);
    if (!v[RES_W-1]) return v;
    if (v[RES_W-2:0] == '0) return {1'b0, {(RES_W-1){1'b1}}};
    return ~v + RES_W'(1);
  endfunction

  // Write qualification, bank-epoch detection and one-hot of the written entry.
  always_comb begin
    wr_ok     = en && wr_valid && (int'(wr_idx) < D);
    new_epoch = !last_seen || (wr_cycle != last_cycle);
    wr_onehot = '0;
    if (int'(wr_idx) < D) wr_onehot[wr_idx] = 1'b1;
  end

  // Entry-valid bits: first write of a new cycle tag restarts that bank's epoch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 4; b++) ent_valid[b] <= '0;
      last_cycle <= '0;
      last_seen  <= 1'b0;
    end else if (wr_ok) begin
      ent_valid[wr_cycle] <= new_epoch ? wr_onehot : (ent_valid[wr_cycle] | wr_onehot);
      last_cycle <= wr_cycle;
      last_seen  <= 1'b1;
    end
  end

  // Sample storage; data needs no reset because validity is tracked separately.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_cycle][wr_idx] <= wr_data;
  end

  // Per-lane compare against current (pre-write) contents; lowest failing lane is captured.
  always_comb begin
    mism      = '0;
    unin      = '0;
    lane_bank = '0;
    lane_idx  = '0;
    lane_data = '0;
    cap_found = 1'b0;
    cap_lane  = '0;
    cap_idx   = '0;
    cap_exp   = '0;
    cap_act   = '0;
    pop       = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_bank = chk_cycle[2*l +: 2];
      lane_idx  = chk_idx[IW*l +: IW];
      lane_data = chk_data[SW*l +: SW];
      if (en && chk_valid[l]) begin
        if (int'(lane_idx) >= D) begin
          unin[l] = 1'b1;
        end else if (!ent_valid[lane_bank][lane_idx]) begin
          unin[l] = 1'b1;
        end else if (mem[lane_bank][lane_idx] != lane_data) begin
          mism[l] = 1'b1;
          pop     = pop + (LW+1)'(1);
          if (!cap_found) begin
            cap_found = 1'b1;
            cap_lane  = LW'(l);
            cap_idx   = lane_idx;
            cap_exp   = mem[lane_bank][lane_idx];
            cap_act   = lane_data;
          end
        end
      end
    end
    err_sum  = {1'b0, err_count} + {{(CNT_W-LW){1'b0}}, pop};
    err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  // Continuity: difference of magnitudes, saturating abs keeps it within RES_W+1 bits.
  always_comb begin
    res_abs  = mag(res_data);
    delta    = (res_abs >= prev_abs) ? {1'b0, res_abs - prev_abs} : {1'b0, prev_abs - res_abs};
    disc_hit = en && res_valid && prev_valid && (delta > {1'b0, DMAX});
  end

  // Status registers; clear takes priority over any check or result event in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse     <= '0;
      err_sticky    <= '0;
      uninit_sticky <= '0;
      err_count     <= '0;
      first_lane    <= '0;
      first_idx     <= '0;
      first_exp     <= '0;
      first_act     <= '0;
      first_armed   <= 1'b1;
      disc_pulse    <= 1'b0;
      disc_count    <= '0;
      prev_abs      <= '0;
      prev_valid    <= 1'b0;
    end else if (clear) begin
      err_pulse     <= '0;
      err_sticky    <= '0;
      uninit_sticky <= '0;
      err_count     <= '0;
      first_lane    <= '0;
      first_idx     <= '0;
      first_exp     <= '0;
      first_act     <= '0;
      first_armed   <= 1'b1;
      disc_pulse    <= 1'b0;
      disc_count    <= '0;
      prev_abs      <= '0;
      prev_valid    <= 1'b0;
    end else begin
      err_pulse     <= mism;
      err_sticky    <= err_sticky | mism;
      uninit_sticky <= uninit_sticky | unin;
      err_count     <= err_next;
      if (first_armed && cap_found) begin
        first_armed <= 1'b0;
        first_lane  <= cap_lane;
        first_idx   <= cap_idx;
        first_exp   <= cap_exp;
        first_act   <= cap_act;
      end
      disc_pulse <= disc_hit;
      if (disc_hit && (disc_count != '1)) disc_count <= disc_count + CNT_W'(1);
      if (!en) begin
        prev_valid <= 1'b0;
      end else if (res_valid) begin
        prev_valid <= 1'b1;
        prev_abs   <= res_abs;
      end
    end
  end

endmodule

// File: tb/tb_batch_sample_scoreboard.sv
// Scenario bench for batch_sample_scoreboard with a queue-based scoreboard of expected strobes.
module tb_batch_sample_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_cycle = '0;
  logic [4:0]  wr_idx = '0;
  logic [3:0]  wr_data = '0;
  logic [2:0]  chk_valid = '0;
  logic [5:0]  chk_cycle = '0;
  logic [14:0] chk_idx = '0;
  logic [11:0] chk_data = '0;
  logic        res_valid = 1'b0;
  logic [23:0] res_data = '0;
  logic [2:0]  err_pulse;
  logic [2:0]  err_sticky;
  logic [2:0]  uninit_sticky;
  logic [15:0] err_count;
  logic [1:0]  first_lane;
  logic [4:0]  first_idx;
  logic [3:0]  first_exp;
  logic [3:0]  first_act;
  logic        disc_pulse;
  logic [15:0] disc_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] exp_pulse_q[$];
  logic       exp_disc_q[$];

  logic [3:0]  ref_mem [4][32];
  logic        ref_ok  [4][32];
  logic [1:0]  ref_last = '0;
  bit          ref_seen = 0;
  logic [23:0] ref_prev = '0;
  bit          ref_prev_ok = 0;

  batch_sample_scoreboard #(.N(4), .DSR(1), .DEPTH(32), .LANES(3), .RES_W(24),
                            .DMAX(24'h04CCCC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .wr_valid(wr_valid), .wr_cycle(wr_cycle), .wr_idx(wr_idx), .wr_data(wr_data),
    .chk_valid(chk_valid), .chk_cycle(chk_cycle), .chk_idx(chk_idx), .chk_data(chk_data),
    .res_valid(res_valid), .res_data(res_data),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .uninit_sticky(uninit_sticky),
    .err_count(err_count), .first_lane(first_lane), .first_idx(first_idx),
    .first_exp(first_exp), .first_act(first_act),
    .disc_pulse(disc_pulse), .disc_count(disc_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_write(input logic [1:0] c, input logic [4:0] i, input logic [3:0] d);
    if (!ref_seen || c != ref_last)
      for (int k = 0; k < 32; k++) ref_ok[c][k] = 1'b0;
    ref_ok[c][i]  = 1'b1;
    ref_mem[c][i] = d;
    ref_last = c;
    ref_seen = 1;
  endtask

  task automatic do_write(input logic [1:0] c, input logic [4:0] i, input logic [3:0] d);
    wr_valid = 1'b1; wr_cycle = c; wr_idx = i; wr_data = d;
    ref_write(c, i, d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [1:0] c, input logic [4:0] i, input logic [3:0] d);
    chk_valid[l] = 1'b1;
    chk_cycle[2*l +: 2] = c;
    chk_idx[5*l +: 5]   = i;
    chk_data[4*l +: 4]  = d;
  endtask

  // Expected strobe from the reference store for the currently driven lanes.
  task automatic push_chk();
    logic [2:0] e;
    logic [1:0] c;
    logic [4:0] i;
    logic [3:0] d;
    e = '0;
    for (int l = 0; l < 3; l++) begin
      c = chk_cycle[2*l +: 2];
      i = chk_idx[5*l +: 5];
      d = chk_data[4*l +: 4];
      if (en && chk_valid[l] && ref_ok[c][i] && ref_mem[c][i] != d) e[l] = 1'b1;
    end
    exp_pulse_q.push_back(e);
  endtask

  function automatic logic [23:0] tb_abs(input logic [23:0] v);
    if (v == 24'h800000) return 24'h7FFFFF;
    if (v[23]) return 24'h0 - v;
    return v;
  endfunction

  task automatic drive_res(input logic [23:0] v);
    logic [23:0] a, b, dd;
    res_valid = 1'b1; res_data = v;
    a = tb_abs(v); b = tb_abs(ref_prev);
    dd = (a > b) ? a - b : b - a;
    exp_disc_q.push_back(en && ref_prev_ok && (dd > 24'h04CCCC));
    ref_prev = v; ref_prev_ok = en;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ref_prev_ok = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (err_pulse !== 3'b0) begin n_bad++; $display("FAIL reset_err_pulse: got %0h want 0", err_pulse); end
    n_cmp++; if (err_sticky !== 3'b0 || uninit_sticky !== 3'b0) begin n_bad++; $display("FAIL reset_sticky: got %0h/%0h want 0/0", err_sticky, uninit_sticky); end
    n_cmp++; if (err_count !== 16'h0 || disc_count !== 16'h0) begin n_bad++; $display("FAIL reset_counts: got %0h/%0h want 0/0", err_count, disc_count); end
    n_cmp++; if ({first_lane, first_idx, first_exp, first_act, disc_pulse} !== 16'h0) begin n_bad++; $display("FAIL reset_first: got %0h want 0", {first_lane, first_idx, first_exp, first_act, disc_pulse}); end
    rst = 1'b0;
    en = 1'b1;
    tick();
  endtask

  task automatic test_reversed_read();
    logic [2:0] e;
    for (int i = 0; i < 32; i++) do_write(2'd0, 5'(i), 4'(i));
    for (int k = 0; k < 32; k++) begin
      set_lane(0, 2'd0, 5'(31 - k), 4'(31 - k));
      push_chk();
      tick();
      chk_valid = '0;
      e = exp_pulse_q.pop_front();
      n_cmp++; if (err_pulse !== e) begin n_bad++; $display("FAIL reversed_read[%0d]: got %0h want %0h", k, err_pulse, e); end
    end
    n_cmp++; if (err_count !== 16'd0 || uninit_sticky !== 3'b0) begin n_bad++; $display("FAIL reversed_read_totals: got %0h/%0h want 0/0", err_count, uninit_sticky); end
  endtask

  task automatic test_single_mismatch();
    logic [2:0] e;
    set_lane(1, 2'd0, 5'd5, 4'h6);
    push_chk();
    tick();
    chk_valid = '0;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e) begin n_bad++; $display("FAIL single_pulse: got %0h want %0h", err_pulse, e); end
    n_cmp++; if ({first_lane, first_idx, first_exp, first_act} !== {2'd1, 5'd5, 4'h5, 4'h6}) begin n_bad++; $display("FAIL single_first: got %0h want %0h", {first_lane, first_idx, first_exp, first_act}, {2'd1, 5'd5, 4'h5, 4'h6}); end
    n_cmp++; if (err_count !== 16'd1 || err_sticky !== 3'b010) begin n_bad++; $display("FAIL single_count: got %0h/%0h want 1/2", err_count, err_sticky); end
    tick();
    n_cmp++; if (err_pulse !== 3'b000) begin n_bad++; $display("FAIL single_pulse_width: got %0h want 0", err_pulse); end
  endtask

  task automatic test_two_lane_fail();
    logic [2:0] e;
    do_clear();
    n_cmp++; if (err_count !== 16'd0 || err_sticky !== 3'b0) begin n_bad++; $display("FAIL clear_counts: got %0h/%0h want 0/0", err_count, err_sticky); end
    set_lane(0, 2'd0, 5'd2, 4'h9);
    set_lane(2, 2'd0, 5'd7, 4'h1);
    push_chk();
    tick();
    chk_valid = '0;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e) begin n_bad++; $display("FAIL two_lane_pulse: got %0h want %0h", err_pulse, e); end
    n_cmp++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL two_lane_count: got %0d want 2", err_count); end
    n_cmp++; if ({first_lane, first_idx, first_exp, first_act} !== {2'd0, 5'd2, 4'h2, 4'h9}) begin n_bad++; $display("FAIL two_lane_first: got %0h want %0h", {first_lane, first_idx, first_exp, first_act}, {2'd0, 5'd2, 4'h2, 4'h9}); end
    set_lane(1, 2'd0, 5'd4, 4'h0);
    push_chk();
    tick();
    chk_valid = '0;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e) begin n_bad++; $display("FAIL later_pulse: got %0h want %0h", err_pulse, e); end
    n_cmp++; if ({first_lane, first_idx, first_exp, first_act} !== {2'd0, 5'd2, 4'h2, 4'h9} || err_count !== 16'd3) begin n_bad++; $display("FAIL first_frozen: got %0h cnt %0d want %0h cnt 3", {first_lane, first_idx, first_exp, first_act}, err_count, {2'd0, 5'd2, 4'h2, 4'h9}); end
  endtask

  task automatic test_read_before_write();
    logic [2:0] e;
    wr_valid = 1'b1; wr_cycle = 2'd0; wr_idx = 5'd10; wr_data = 4'h3;
    set_lane(0, 2'd0, 5'd10, 4'hA);
    push_chk();
    ref_write(2'd0, 5'd10, 4'h3);
    tick();
    wr_valid = 1'b0; chk_valid = '0;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e) begin n_bad++; $display("FAIL rbw_old: got %0h want %0h", err_pulse, e); end
    set_lane(0, 2'd0, 5'd10, 4'hA);
    push_chk();
    tick();
    chk_valid = '0;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e) begin n_bad++; $display("FAIL rbw_new: got %0h want %0h", err_pulse, e); end
    n_cmp++; if (err_count !== 16'd4) begin n_bad++; $display("FAIL rbw_count: got %0d want 4", err_count); end
  endtask

  task automatic test_uninit();
    logic [2:0] e;
    do_clear();
    do_write(2'd1, 5'd0, 4'h7);
    set_lane(2, 2'd1, 5'd3, 4'h5);
    set_lane(0, 2'd1, 5'd0, 4'h7);
    push_chk();
    tick();
    chk_valid = '0;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e) begin n_bad++; $display("FAIL uninit_pulse: got %0h want %0h", err_pulse, e); end
    n_cmp++; if (uninit_sticky !== 3'b100 || err_count !== 16'd0) begin n_bad++; $display("FAIL uninit_flag: got %0h cnt %0d want 4 cnt 0", uninit_sticky, err_count); end
    do_write(2'd0, 5'd0, 4'h0);
    set_lane(1, 2'd0, 5'd5, 4'h5);
    push_chk();
    tick();
    chk_valid = '0;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e || uninit_sticky !== 3'b110) begin n_bad++; $display("FAIL epoch_clear: got %0h/%0h want %0h/6", err_pulse, uninit_sticky, e); end
    en = 1'b0;
    set_lane(0, 2'd0, 5'd0, 4'hF);
    push_chk();
    tick();
    chk_valid = '0;
    en = 1'b1;
    e = exp_pulse_q.pop_front();
    n_cmp++; if (err_pulse !== e || err_count !== 16'd0) begin n_bad++; $display("FAIL en_low: got %0h cnt %0d want %0h cnt 0", err_pulse, err_count, e); end
  endtask

  task automatic test_continuity();
    logic e;
    logic [23:0] seq [9];
    seq = '{24'h100000, 24'h180000, 24'h1C0000, 24'hE40000, 24'h800000,
            24'h000000, 24'h04CCCC, 24'h000000, 24'h04CCCD};
    do_clear();
    for (int k = 0; k < 9; k++) begin
      if (k == 5) begin
        en = 1'b0;
        ref_prev_ok = 0;
        tick();
        en = 1'b1;
      end
      drive_res(seq[k]);
      tick();
      res_valid = 1'b0;
      e = exp_disc_q.pop_front();
      n_cmp++; if (disc_pulse !== e) begin n_bad++; $display("FAIL disc_pulse[%0d]: got %0b want %0b", k, disc_pulse, e); end
      if (k == 1) begin
        n_cmp++; if (disc_count !== 16'd1) begin n_bad++; $display("FAIL disc_count_first: got %0d want 1", disc_count); end
      end
    end
    n_cmp++; if (disc_count !== 16'd3) begin n_bad++; $display("FAIL disc_count_total: got %0d want 3", disc_count); end
  endtask

  task automatic test_saturation_and_reset();
    do_clear();
    set_lane(0, 2'd0, 5'd0, 4'hF);
    set_lane(1, 2'd0, 5'd0, 4'hF);
    set_lane(2, 2'd0, 5'd0, 4'hF);
    for (int k = 0; k < 21845; k++) tick();
    n_cmp++; if (err_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach: got %0h want ffff", err_count); end
    tick();
    n_cmp++; if (err_count !== 16'hFFFF || err_pulse !== 3'b111) begin n_bad++; $display("FAIL sat_hold: got %0h/%0h want ffff/7", err_count, err_pulse); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({err_pulse, err_sticky, uninit_sticky} !== 9'h0 || err_count !== 16'h0) begin n_bad++; $display("FAIL midrst_flags: got %0h cnt %0h want 0", {err_pulse, err_sticky, uninit_sticky}, err_count); end
    n_cmp++; if ({first_lane, first_idx, first_exp, first_act, disc_pulse} !== 16'h0 || disc_count !== 16'h0) begin n_bad++; $display("FAIL midrst_other: got %0h/%0h want 0", {first_lane, first_idx, first_exp, first_act, disc_pulse}, disc_count); end
    chk_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (err_pulse !== 3'b0 || disc_pulse !== 1'b0) begin n_bad++; $display("FAIL release_pulse: got %0h/%0b want 0/0", err_pulse, disc_pulse); end
    set_lane(0, 2'd0, 5'd0, 4'hF);
    tick();
    chk_valid = '0;
    n_cmp++; if (uninit_sticky !== 3'b001 || err_pulse !== 3'b0) begin n_bad++; $display("FAIL post_reset_uninit: got %0h/%0h want 1/0", uninit_sticky, err_pulse); end
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 32; i++) begin
        ref_ok[b][i] = 1'b0;
        ref_mem[b][i] = '0;
      end
    test_reset();
    test_reversed_read();
    test_single_mismatch();
    test_two_lane_fail();
    test_read_before_write();
    test_uninit();
    test_continuity();
    test_saturation_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
